mips_fetch: RTL and testbench
=============================

MIPS_FETCH -- requirements
Module: mips_fetch

Interface
REQ-001 The module SHALL have parameter PC_W, default 32, giving the width of the word-addressed program counter.
REQ-002 The module SHALL have parameter RESET_PC, default 0, giving the PC value loaded on reset.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-005 The module SHALL have port fetch_en, input, 1 bit, which permits the start of new fetches.
REQ-006 The module SHALL have port imem_req, output, 1 bit, the instruction-memory read request.
REQ-007 The module SHALL have port imem_addr, output, PC_W bits, the read address (word index).
REQ-008 The module SHALL have port imem_ack, input, 1 bit, indicating imem_rdata is valid this cycle.
REQ-009 The module SHALL have port imem_rdata, input, 16 bits, the instruction word: [15:12] opcode, [5:0] signed branch offset.
REQ-010 The module SHALL have port instr, output, 16 bits, the instruction presented to the control decoder.
REQ-011 The module SHALL have port instr_valid, output, 1 bit, which qualifies instr.
REQ-012 The module SHALL have port instr_ready, input, 1 bit, the decoder's accept signal.
REQ-013 The module SHALL have port pc_out, output, PC_W bits, the PC of the instruction on instr.
REQ-014 The module SHALL have port br_res_valid, input, 1 bit, a branch-resolution strobe from the ALU stage.
REQ-015 The module SHALL have port alu_zero, input, 1 bit, the ALU zero flag, sampled with br_res_valid.
REQ-016 The module SHALL have port br_taken, output, 1 bit, a one-cycle pulse when a branch redirects the PC.

Function
REQ-017 The module SHALL implement the FSM states IDLE, FETCH, ISSUE and BR_WAIT.
REQ-018 In IDLE, when fetch_en=1, the module SHALL move to FETCH on the next edge.
REQ-019 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, held stable until imem_ack.
REQ-020 In FETCH, on imem_ack=1 the module SHALL register imem_rdata into instr and move to ISSUE.
REQ-021 The minimum latency SHALL be 1 cycle: imem_ack in the first FETCH cycle gives instr_valid=1 on the next cycle.
REQ-022 In ISSUE, instr_valid SHALL be 1; instr and pc_out SHALL be held stable until instr_ready=1.
REQ-023 An instruction SHALL be a branch when opcode[2:0] is 101 (BEQ) or 110 (BNE).
REQ-024 On the ISSUE handshake of a non-branch, pc SHALL become pc+1, and the next state SHALL be FETCH if fetch_en=1, otherwise IDLE.
REQ-025 On the ISSUE handshake of a branch, the module SHALL go to BR_WAIT without changing pc.
REQ-026 In BR_WAIT, instr_valid SHALL be 0 and imem_req SHALL be 0.
REQ-027 In BR_WAIT, on br_res_valid=1, taken SHALL be (BEQ and alu_zero=1) or (BNE and alu_zero=0).
REQ-028 On resolution, pc SHALL become pc+1+sign-extended offset[5:0] when taken, otherwise pc+1.
REQ-029 On resolution, br_taken SHALL pulse for exactly one cycle when taken.
REQ-030 On resolution, the next state SHALL be FETCH if fetch_en=1, otherwise IDLE.
REQ-031 All PC arithmetic SHALL be modulo 2^PC_W, so 2^PC_W-1 plus 1 wraps to 0 and negative offsets wrap.
REQ-032 A fetch_en drop during FETCH SHALL NOT abort the outstanding request; the module SHALL complete FETCH and ISSUE, then go to IDLE.
REQ-033 imem_ack outside FETCH, br_res_valid outside BR_WAIT and instr_ready outside ISSUE SHALL be ignored.
REQ-034 If instr_ready and br_res_valid are both 1 in ISSUE for a branch, br_res_valid SHALL be ignored; resolution is accepted only in BR_WAIT.

Reset
REQ-035 While reset_n=0, regardless of clk, the state SHALL be IDLE, pc SHALL equal RESET_PC, and imem_addr and pc_out SHALL equal RESET_PC.
REQ-036 While reset_n=0, imem_req, instr_valid and br_taken SHALL be 0 and instr SHALL be 16'h0000.
REQ-037 Reset asserted mid-FETCH or mid-BR_WAIT SHALL discard the outstanding request or branch, and a later ack or resolution SHALL have no effect.

Verification
REQ-038 Reset release with fetch_en=1 and imem_ack tied high, opcode 0000 words -> imem_addr 0,1,2,...; each instr_valid is one cycle after its ack.
REQ-039 BEQ at pc=4 with offset 6'h3E (-2) and alu_zero=1 -> br_taken pulse; next imem_addr=3.
REQ-040 BNE at pc=4 with offset 6'h05 and alu_zero=1 -> no br_taken; next imem_addr=5.
REQ-041 instr_ready held low for 5 cycles in ISSUE -> instr and pc_out stable, instr_valid stays 1, no new imem_req.
REQ-042 PC_W=4, pc=15, non-branch accepted -> next imem_addr=0.
REQ-043 reset_n pulsed low during FETCH at pc=7, then a stray imem_ack -> outputs at reset values, pc=0, ack ignored.

Source files
------------

// File: rtl/mips_fetch.sv
// Instruction fetch unit: fetches one word at a time, presents it to the decoder and,
// for BEQ/BNE, holds the PC until the ALU stage resolves the branch.
module mips_fetch #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fetch_en,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [PC_W-1:0] pc_out,
  input  logic            br_res_valid,
  input  logic            alu_zero,
  output logic            br_taken
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StIssue,
    StBrWait
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;
  logic            br_taken_q, br_taken_d;

  logic [2:0]      op_lo;
  logic            is_beq, is_bne, is_branch;
  logic            resolve_taken;
  logic [PC_W-1:0] pc_inc, br_off, pc_tgt;

  // The held instruction word still describes the branch while waiting in StBrWait.
  assign op_lo     = instr_q[14:12];
  assign is_beq    = (op_lo == 3'b101);
  assign is_bne    = (op_lo == 3'b110);
  assign is_branch = is_beq | is_bne;

  assign resolve_taken = (is_beq & alu_zero) | (is_bne & ~alu_zero);

  // Size cast sign-extends or truncates the 6-bit offset to the PC width.
  assign br_off = PC_W'($signed(instr_q[5:0]));
  assign pc_inc = pc_q + PC_W'(1);
  assign pc_tgt = pc_inc + br_off;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    br_taken_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fetch_en) state_d = StFetch;
      end
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (instr_ready) begin
          if (is_branch) begin
            state_d = StBrWait;
          end else begin
            pc_d    = pc_inc;
            state_d = fetch_en ? StFetch : StIdle;
          end
        end
      end
      StBrWait: begin
        if (br_res_valid) begin
          br_taken_d = resolve_taken;
          pc_d       = resolve_taken ? pc_tgt : pc_inc;
          state_d    = fetch_en ? StFetch : StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_q    <= 16'h0000;
      br_taken_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign imem_req    = (state_q == StFetch);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == StIssue);
  assign pc_out      = pc_q;
  assign br_taken    = br_taken_q;

endmodule

// File: tb/tb_mips_fetch.sv
// Bench for mips_fetch: directed scenarios followed by random instruction streams, all
// checked against an instruction-level PC model using plain modular arithmetic.
module tb_mips_fetch;

  localparam int unsigned PC_W  = 4;
  localparam int          PcMod = 16;

  logic            clk;
  logic            reset_n;
  logic            fetch_en;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;
  logic [15:0]     instr;
  logic            instr_valid;
  logic            instr_ready;
  logic [PC_W-1:0] pc_out;
  logic            br_res_valid;
  logic            alu_zero;
  logic            br_taken;

  int errors = 0;
  int checks = 0;
  int pc_m   = 0;

  mips_fetch #(
    .PC_W     (PC_W),
    .RESET_PC (4'd0)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fetch_en     (fetch_en),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc_out       (pc_out),
    .br_res_valid (br_res_valid),
    .alu_zero     (alu_zero),
    .br_taken     (br_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_pc_out"}, 32'(pc_out), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_br_taken"}, 32'(br_taken), 32'd0);
    chk({tag, "_instr"}, 32'(instr), 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must respond without a clock edge.
  task automatic do_reset();
    reset_n      = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    fetch_en     = 1'b0;
    imem_ack     = 1'b0;
    instr_ready  = 1'b0;
    br_res_valid = 1'b0;
    alu_zero     = 1'b0;
    repeat (2) tick();
    chk_reset_outputs("rst_held");
    pc_m = 0;
  endtask

  function automatic int next_pc(input int pc, input logic [15:0] w, input logic taken);
    int off;
    off = int'(w[5:0]);
    if (w[5]) off -= 64;
    return (((pc + 1 + (taken ? off : 0)) % PcMod) + PcMod) % PcMod;
  endfunction

  // One full instruction, entered with the DUT in its fetch phase at pc_m.
  task automatic do_instr(input logic [15:0] w, input int ack_dly, input int stall,
                          input int br_dly, input logic z, input logic fe_after);
    logic [2:0] op;
    logic       is_br;
    logic       taken;
    op    = w[14:12];
    is_br = (op == 3'b101) || (op == 3'b110);
    taken = ((op == 3'b101) && z) || ((op == 3'b110) && !z);

    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", 32'(imem_addr), 32'(pc_m));
    for (int i = 0; i < ack_dly; i++) begin
      fetch_en     = 1'($urandom_range(1));
      br_res_valid = 1'($urandom_range(1));
      instr_ready  = 1'($urandom_range(1));
      tick();
      chk("fetch_req_hold", 32'(imem_req), 32'd1);
      chk("fetch_addr_hold", 32'(imem_addr), 32'(pc_m));
    end
    br_res_valid = 1'b0;
    instr_ready  = 1'b0;
    imem_ack     = 1'b1;
    imem_rdata   = w;
    tick();
    imem_ack     = 1'b0;
    imem_rdata   = 16'($urandom);
    chk("issue_valid", 32'(instr_valid), 32'd1);
    chk("issue_instr", 32'(instr), 32'(w));
    chk("issue_pc", 32'(pc_out), 32'(pc_m));
    chk("issue_req", 32'(imem_req), 32'd0);

    for (int i = 0; i < stall; i++) begin
      imem_ack     = 1'($urandom_range(1));
      br_res_valid = 1'($urandom_range(1));
      tick();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", 32'(instr), 32'(w));
      chk("stall_pc", 32'(pc_out), 32'(pc_m));
      chk("stall_req", 32'(imem_req), 32'd0);
    end

    imem_ack     = 1'b0;
    instr_ready  = 1'b1;
    fetch_en     = fe_after;
    br_res_valid = 1'($urandom_range(1));
    alu_zero     = 1'($urandom_range(1));
    tick();
    instr_ready  = 1'b0;
    br_res_valid = 1'b0;

    if (!is_br) begin
      pc_m = next_pc(pc_m, w, 1'b0);
      chk("seq_addr", 32'(imem_addr), 32'(pc_m));
      chk("seq_req", 32'(imem_req), 32'(fe_after));
      chk("seq_valid", 32'(instr_valid), 32'd0);
      chk("seq_br_taken", 32'(br_taken), 32'd0);
    end else begin
      chk("bw_valid", 32'(instr_valid), 32'd0);
      chk("bw_req", 32'(imem_req), 32'd0);
      chk("bw_addr", 32'(imem_addr), 32'(pc_m));
      for (int i = 0; i < br_dly; i++) begin
        imem_ack    = 1'($urandom_range(1));
        instr_ready = 1'($urandom_range(1));
        fetch_en    = 1'($urandom_range(1));
        tick();
        chk("bw_wait_valid", 32'(instr_valid), 32'd0);
        chk("bw_wait_req", 32'(imem_req), 32'd0);
      end
      imem_ack     = 1'b0;
      instr_ready  = 1'b0;
      br_res_valid = 1'b1;
      alu_zero     = z;
      fetch_en     = fe_after;
      tick();
      br_res_valid = 1'b0;
      pc_m = next_pc(pc_m, w, taken);
      chk("res_br_taken", 32'(br_taken), 32'(taken));
      chk("res_addr", 32'(imem_addr), 32'(pc_m));
      chk("res_req", 32'(imem_req), 32'(fe_after));
      if (fe_after) begin
        tick();
        chk("res_pulse_end", 32'(br_taken), 32'd0);
      end
    end

    if (!fe_after) begin
      tick();
      chk("idle_req", 32'(imem_req), 32'd0);
      chk("idle_br_taken", 32'(br_taken), 32'd0);
      fetch_en = 1'b1;
      tick();
      chk("idle_to_fetch", 32'(imem_req), 32'd1);
    end
  endtask

  initial begin
    reset_n      = 1'b1;
    fetch_en     = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = 16'h0000;
    instr_ready  = 1'b0;
    br_res_valid = 1'b0;
    alu_zero     = 1'b0;
    #2;
    do_reset();

    // Sequential stream with zero-latency acks from reset.
    fetch_en = 1'b1;
    reset_n  = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) do_instr(16'h0000, 0, 0, 0, 1'b0, 1'b1);

    // BEQ at pc=4, offset -2, taken -> 3.
    do_instr(16'h503E, 0, 0, 2, 1'b1, 1'b1);
    chk("beq_target", 32'(imem_addr), 32'd3);
    // BNE at pc=4, offset 5, alu_zero=1 -> not taken -> 5.
    do_instr(16'h0000, 0, 0, 0, 1'b0, 1'b1);
    do_instr(16'h6005, 1, 0, 0, 1'b1, 1'b1);
    chk("bne_fallthru", 32'(imem_addr), 32'd5);

    // Decoder back-pressure for 5 cycles.
    do_instr(16'h1234, 2, 5, 0, 1'b0, 1'b1);
    do_instr(16'h7FFF, 0, 1, 0, 1'b0, 1'b0);

    // Reset in the middle of a fetch at pc=7, then a stray ack.
    chk("pre_rst_addr", 32'(imem_addr), 32'd7);
    do_reset();
    reset_n  = 1'b1;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk_reset_outputs("stray_ack");
    fetch_en = 1'b1;
    tick();

    // Reset while a branch waits for resolution, then a stray resolution.
    chk("pre_bw_req", 32'(imem_req), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 16'h5001;
    tick();
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("bw_entered", 32'(instr_valid), 32'd0);
    do_reset();
    reset_n      = 1'b1;
    br_res_valid = 1'b1;
    alu_zero     = 1'b1;
    tick();
    br_res_valid = 1'b0;
    chk_reset_outputs("stray_res");
    fetch_en = 1'b1;
    tick();

    // Sixteen non-branches wrap the 4-bit PC from 15 back to 0.
    for (int i = 0; i < 16; i++) do_instr({4'h0, 12'(i)}, 0, 0, 0, 1'b0, 1'b1);
    chk("wrap_addr", 32'(imem_addr), 32'd0);

    // Random instruction stream.
    for (int n = 0; n < 120; n++) begin
      do_instr(16'($urandom), int'($urandom_range(3)), int'($urandom_range(3)),
               int'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
